// File: rtl/mem_debug_arbiter.sv
// Shares the data BRAM port between the CPU datapath and a push-button debug read.
// A debounced button press steals two stalled cycles to read one word at dbg_addr.
module mem_debug_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_WAIT        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        button,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] mem_rdata,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  output logic [7:0]  dbg_count
);

  // state    | meaning
  // IDLE     | CPU owns the BRAM port; pending debug read waits for a gap
  // DBG_ADDR | debug address presented, CPU stalled
  // DBG_DATA | BRAM data valid, captured at the end of this cycle

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, DBG_ADDR, DBG_DATA} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_level_q, deb_level_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            pending_q, pending_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     dbg_data_q, dbg_data_d;
  logic            dbg_valid_q, dbg_valid_d;
  logic [7:0]      dbg_count_q, dbg_count_d;
  logic            stall_q, stall_d;
  logic            deb_rise;
  logic            go;

  always_comb begin
    state_d     = state_q;
    sync1_d     = button;
    sync2_d     = sync1_q;
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    pending_d   = pending_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = 1'b0;
    dbg_count_d = dbg_count_q;
    deb_rise    = 1'b0;

    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_level_d = sync2_q;
        deb_rise    = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end

    go = (state_q == IDLE) && pending_q &&
         (!cpu_req || (wait_cnt_q == WW'(MAX_WAIT - 1)));

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = DBG_ADDR;
          pending_d  = 1'b0;
          wait_cnt_d = '0;
          addr_d     = dbg_addr;
        end else begin
          // a rise while a read is already pending is dropped, not queued
          if (deb_rise && !pending_q) pending_d = 1'b1;
          if (pending_q && cpu_req) wait_cnt_d = wait_cnt_q + WW'(1);
          else                      wait_cnt_d = '0;
        end
      end
      DBG_ADDR: state_d = DBG_DATA;
      DBG_DATA: begin
        state_d     = IDLE;
        dbg_data_d  = mem_rdata;
        dbg_count_d = dbg_count_q + 8'd1;
        dbg_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      pending_q   <= 1'b0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_count_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      pending_q   <= pending_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_count_q <= dbg_count_d;
      stall_q     <= stall_d;
    end
  end

  // CPU path is combinational in IDLE so loads/stores see no added latency
  always_comb begin
    if (state_q == IDLE) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_req & cpu_we;
    end else begin
      mem_addr = {6'b0, addr_q};
      mem_we   = 1'b0;
    end
    mem_wdata = cpu_wdata;
  end

  assign cpu_stall = stall_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_count = dbg_count_q;

endmodule

// File: tb/tb_mem_debug_arbiter.sv
// Directed bench for mem_debug_arbiter: a default instance with a BRAM model and a
// fast-debounce instance used to land a second press inside a running read.
module tb_mem_debug_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, button;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [4:0]  dbg_addr;
  logic [31:0] mem_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic [7:0]  dbg_count;

  logic        f_cpu_req, f_cpu_we, f_button;
  logic [10:0] f_cpu_addr;
  logic [31:0] f_cpu_wdata;
  logic [4:0]  f_dbg_addr;
  logic [31:0] f_rdata;
  logic [10:0] f_mem_addr;
  logic        f_mem_we;
  logic [31:0] f_mem_wdata;
  logic        f_cpu_stall;
  logic [31:0] f_dbg_data;
  logic        f_dbg_valid;
  logic [7:0]  f_dbg_count;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_debug_arbiter u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .button(button), .dbg_addr(dbg_addr), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_stall(cpu_stall),
    .dbg_data(dbg_data), .dbg_valid(dbg_valid), .dbg_count(dbg_count)
  );

  mem_debug_arbiter #(.DEBOUNCE_CYCLES(2), .MAX_WAIT(8)) u_fast (
    .clk(clk), .rst(rst), .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr),
    .cpu_wdata(f_cpu_wdata), .button(f_button), .dbg_addr(f_dbg_addr), .mem_rdata(f_rdata),
    .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_wdata(f_mem_wdata), .cpu_stall(f_cpu_stall),
    .dbg_data(f_dbg_data), .dbg_valid(f_dbg_valid), .dbg_count(f_dbg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data BRAM: synchronous write, one-cycle registered read
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) f_rdata <= {21'd0, f_mem_addr} ^ 32'hA5A5_0000;

  int stall_cyc = 0, valid_cnt = 0, we_viol = 0, run = 0, last_run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_stall) begin
        stall_cyc <= stall_cyc + 1;
        run       <= run + 1;
        if (mem_we) we_viol <= we_viol + 1;
      end else if (run != 0) begin
        last_run <= run;
        run      <= 0;
      end
      if (dbg_valid) valid_cnt <= valid_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // press the button at a negedge, release after `hold` cycles, time stall and valid
  task automatic press_measure(input int hold, output int t_stall, output int t_valid,
                               output logic [10:0] a_stall);
    t_stall = 0;
    t_valid = 0;
    a_stall = '0;
    button  = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == hold) button = 1'b0;
      if (cpu_stall && t_stall == 0) begin
        t_stall = i;
        a_stall = mem_addr;
      end
      if (dbg_valid) begin
        t_valid = i;
        break;
      end
    end
    button = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  int s_stall, s_valid, s_we, t_st, t_va, hit;
  logic [10:0] a_st;

  initial begin
    rst = 1'b1;
    {cpu_req, cpu_we, button} = '0;
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0;
    {f_cpu_req, f_cpu_we, f_button} = '0;
    f_cpu_addr = '0; f_cpu_wdata = '0; f_dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_valid", 32'(dbg_valid), 32'd0);
    check("rst_count", 32'(dbg_count), 32'd0);
    check("rst_data", dbg_data, 32'd0);

    // preload word 5 through the CPU store path
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd5; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    check("pass_addr", 32'(mem_addr), 32'd5);
    check("pass_we", 32'(mem_we), 32'd1);
    check("pass_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check("pass_no_req_we", 32'(mem_we), 32'd0);
    repeat (3) @(negedge clk);

    // reset asserted during DBG_ADDR abandons the read
    dbg_addr = 5'd5;
    button   = 1'b1;
    hit      = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 18) button = 1'b0;
      if (cpu_stall) begin
        hit = i;
        break;
      end
    end
    check("rst_mid_stall_time", 32'(hit), 32'd19);
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(cpu_stall), 32'd0);
    check("rst_mid_count", 32'(dbg_count), 32'd0);
    check("rst_mid_data", dbg_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_stall = stall_cyc; s_valid = valid_cnt;
    repeat (40) @(negedge clk);
    check("rst_mid_no_restall", 32'(stall_cyc - s_stall), 32'd0);
    check("rst_mid_no_valid", 32'(valid_cnt - s_valid), 32'd0);
    check("rst_mid_count_after", 32'(dbg_count), 32'd0);

    // 10-cycle glitch never survives a 16-cycle debounce
    s_stall = stall_cyc; s_valid = valid_cnt;
    button = 1'b1;
    repeat (10) @(negedge clk);
    button = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_stall", 32'(stall_cyc - s_stall), 32'd0);
    check("glitch_valid", 32'(valid_cnt - s_valid), 32'd0);
    check("glitch_count", 32'(dbg_count), 32'd0);

    // clean press with idle CPU
    s_stall = stall_cyc; s_valid = valid_cnt; s_we = we_viol;
    press_measure(20, t_st, t_va, a_st);
    check("rd1_stall_time", 32'(t_st), 32'd19);
    check("rd1_valid_time", 32'(t_va), 32'd21);
    check("rd1_addr", 32'(a_st), 32'd5);
    check("rd1_stall_cycles", 32'(stall_cyc - s_stall), 32'd2);
    check("rd1_run", 32'(last_run), 32'd2);
    check("rd1_valid_pulses", 32'(valid_cnt - s_valid), 32'd1);
    check("rd1_we_in_stall", 32'(we_viol - s_we), 32'd0);
    check("rd1_data", dbg_data, 32'hDEAD_BEEF);
    check("rd1_count", 32'(dbg_count), 32'd1);

    // store then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd3; cpu_wdata = 32'h1234_5678;
    #1;
    check("st3_addr", 32'(mem_addr), 32'd3);
    check("st3_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    dbg_addr = 5'd3;
    press_measure(20, t_st, t_va, a_st);
    check("rd3_valid_time", 32'(t_va), 32'd21);
    check("rd3_data", dbg_data, 32'h1234_5678);
    check("rd3_count", 32'(dbg_count), 32'd2);
    dbg_addr = 5'd9;
    repeat (5) @(negedge clk);
    check("data_hold", dbg_data, 32'h1234_5678);

    // CPU busy every cycle: read forced after MAX_WAIT waiting cycles
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd100; cpu_wdata = 32'hCAFE_0000;
    dbg_addr = 5'd5;
    s_stall = stall_cyc; s_valid = valid_cnt; s_we = we_viol;
    press_measure(20, t_st, t_va, a_st);
    check("wait_stall_time", 32'(t_st), 32'd26);
    check("wait_valid_time", 32'(t_va), 32'd28);
    check("wait_addr", 32'(a_st), 32'd5);
    check("wait_stall_cycles", 32'(stall_cyc - s_stall), 32'd2);
    check("wait_run", 32'(last_run), 32'd2);
    check("wait_we_in_stall", 32'(we_viol - s_we), 32'd0);
    check("wait_valid_pulses", 32'(valid_cnt - s_valid), 32'd1);
    check("wait_data", dbg_data, 32'hDEAD_BEEF);
    check("wait_count", 32'(dbg_count), 32'd3);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // fast instance: second debounced rise lands during DBG_DATA and is dropped
    f_cpu_req = 1'b1; f_cpu_we = 1'b1; f_cpu_addr = 11'h40; f_cpu_wdata = 32'h0BAD_F00D;
    f_dbg_addr = 5'd7;
    #1;
    check("f_pass_addr", 32'(f_mem_addr), 32'h40);
    check("f_pass_we", 32'(f_mem_we), 32'd1);
    check("f_pass_wdata", f_mem_wdata, 32'h0BAD_F00D);
    @(negedge clk);
    t_va = 0; s_valid = 0; s_stall = 0; s_we = 0;
    f_button = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4)  f_button = 1'b0;
      if (i == 10) f_button = 1'b1;
      if (f_cpu_stall) begin
        s_stall++;
        if (f_mem_we) s_we++;
      end
      if (f_dbg_valid) begin
        s_valid++;
        if (t_va == 0) t_va = i;
      end
    end
    check("f_valid_time", 32'(t_va), 32'd14);
    check("f_valid_pulses", 32'(s_valid), 32'd1);
    check("f_stall_cycles", 32'(s_stall), 32'd2);
    check("f_we_in_stall", 32'(s_we), 32'd0);
    check("f_count", 32'(f_dbg_count), 32'd1);
    check("f_data", f_dbg_data, 32'hA5A5_0007);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_debug_arbiter.md
MEM_DEBUG_ARBITER -- requirements
Module: mem_debug_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized cycles required to accept a button level change.
REQ-002 Parameter MAX_WAIT, default 8, maximum cycles a pending debug read waits on an active CPU access before it is forced.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU datapath performs a data-memory access this cycle (load or store).
REQ-006 cpu_we  input  1  CPU store enable; meaningful only with cpu_req.
REQ-007 cpu_addr  input  11  CPU data-memory word address (ALU result).
REQ-008 cpu_wdata  input  32  CPU store data (rt value).
REQ-009 button  input  1  raw, unsynchronized debug-read push button.
REQ-010 dbg_addr  input  5  switch-selected debug word address.
REQ-011 mem_rdata  input  32  data BRAM read port; valid one clk cycle after the address is presented.
REQ-012 mem_addr  output  11  data BRAM address.
REQ-013 mem_we  output  1  data BRAM write enable.
REQ-014 mem_wdata  output  32  data BRAM write data.
REQ-015 cpu_stall  output  1  freezes the PC and register write-back while high.
REQ-016 dbg_data  output  32  last word captured by a debug read.
REQ-017 dbg_valid  output  1  one-cycle pulse when dbg_data updates.
REQ-018 dbg_count  output  8  number of completed debug reads, wraps 255->0.

Function
REQ-019 button SHALL pass through a 2-flop synchronizer before any other use.
REQ-020 Debounced level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets the debounce counter.
REQ-021 A debounced 0->1 transition SHALL set a one-deep pending flag; a transition arriving while pending is already set or a debug read is in progress SHALL be dropped.
REQ-022 FSM states: IDLE, DBG_ADDR, DBG_DATA.
REQ-023 IDLE: mem_addr=cpu_addr, mem_we=cpu_req&cpu_we, mem_wdata=cpu_wdata (combinational pass-through), cpu_stall=0.
REQ-024 IDLE->DBG_ADDR when pending=1 and (cpu_req=0 or wait counter = MAX_WAIT-1); at this edge dbg_addr is registered and pending clears.
REQ-025 Wait counter SHALL increment each IDLE cycle with pending=1 and cpu_req=1, and clear on entering DBG_ADDR or when pending=0.
REQ-026 DBG_ADDR: mem_addr={6'b0, registered dbg_addr}, mem_we=0, cpu_stall=1; unconditional next state DBG_DATA.
REQ-027 DBG_DATA: mem_addr held, mem_we=0, cpu_stall=1; at its end edge dbg_data<=mem_rdata, dbg_count increments, next state IDLE.
REQ-028 dbg_valid SHALL be high exactly in the first IDLE cycle after DBG_DATA.
REQ-029 A debug read SHALL occupy exactly 2 stalled cycles; a CPU store SHALL never be issued during DBG_ADDR/DBG_DATA (the stalled CPU retries after release).
REQ-030 Debug press to dbg_valid latency SHALL be 3 cycles after pending sets with cpu_req=0, at most MAX_WAIT+2 otherwise.
REQ-031 dbg_data SHALL hold its value between reads; cpu_stall SHALL never be high in IDLE.

Reset
REQ-032 On rst: state IDLE, synchronizer, debounce level/counter, pending, wait counter, registered address, dbg_data, dbg_valid, dbg_count all 0.
REQ-033 rst asserted mid-read SHALL immediately drop cpu_stall and abandon the read without updating dbg_data or dbg_count.

Verification
REQ-034 Button high 20 cycles, cpu_req=0, dbg_addr=5, mem word 5=0xDEADBEEF -> one DBG_ADDR/DBG_DATA pair, dbg_data=0xDEADBEEF, dbg_valid one pulse, dbg_count=1.
REQ-035 Button glitch high 10 cycles (DEBOUNCE_CYCLES=16) -> no pending, no stall, dbg_count=0.
REQ-036 Pending with cpu_req held 1 -> cpu_stall rises after exactly MAX_WAIT=8 waiting cycles, 2 stall cycles, mem_we=0 throughout.
REQ-037 CPU store addr 3 data 0x12345678 in IDLE, then debug read dbg_addr=3 -> dbg_data=0x12345678.
REQ-038 Second press during DBG_DATA -> dropped, dbg_count increments by 1 only.
REQ-039 rst pulse during DBG_ADDR -> cpu_stall=0 same cycle, dbg_data and dbg_count remain 0, state IDLE.
